// File: rtl/input_write_addr_gen.sv
// Write-side address generator for the ping-pong input activation bank.
// Optional stall counter output is enabled by defining INPUT_WRITE_ADDR_GEN_STATS_EN.
module input_write_addr_gen #(
  parameter int COUNTER_WIDTH   = 32,
  parameter int BANK_ADDR_WIDTH = 8,
  parameter int DATA_WIDTH      = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         config_enable,
  input  logic [3*COUNTER_WIDTH-1:0]   config_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         wen,
  output logic                         wbank,
  output logic [BANK_ADDR_WIDTH-1:0]   waddr,
  output logic [DATA_WIDTH-1:0]        wdata,
  output logic                         rbank,
  output logic                         rbank_valid,
  input  logic                         read_done
`ifdef INPUT_WRITE_ADDR_GEN_STATS_EN
  ,
  output logic [COUNTER_WIDTH-1:0]     stall_count
`endif
);

  localparam logic [COUNTER_WIDTH-1:0] ZERO_C = '0;
  localparam logic [COUNTER_WIDTH-1:0] ONE_C  = COUNTER_WIDTH'(1);

  logic [COUNTER_WIDTH-1:0]   ix0_q, iy0_q, ic1_q, ix0_d, iy0_d, ic1_d;
  logic [COUNTER_WIDTH-1:0]   ix_q, iy_q, ic_q, lin_q, ix_d, iy_d, ic_d, lin_d;
  logic                       wptr_q, wptr_d, rbank_q, rbank_d;
  logic [1:0]                 full_q, full_d;
  logic                       pend_q, pend_d, pend_bank_q, pend_bank_d;
  logic                       wen_q, wen_d, wbank_q, wbank_d;
  logic [BANK_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;

  logic       cfg_ok_s, in_ready_s, accept_s, rd_ok_s;
  logic       ix_wrap_s, iy_wrap_s, ic_wrap_s, last_s;
  logic [1:0] full_set_s, full_clr_s;

  assign cfg_ok_s   = (ix0_q != ZERO_C) & (iy0_q != ZERO_C) & (ic1_q != ZERO_C);
  assign in_ready_s = cfg_ok_s & ~full_q[wptr_q];
  assign accept_s   = in_valid & in_ready_s;
  assign ix_wrap_s  = (ix_q == ix0_q - ONE_C);
  assign iy_wrap_s  = (iy_q == iy0_q - ONE_C);
  assign ic_wrap_s  = (ic_q == ic1_q - ONE_C);
  assign last_s     = ix_wrap_s & iy_wrap_s & ic_wrap_s;
  assign rd_ok_s    = read_done & full_q[rbank_q];
  // Pending marks the half whose last write is committing this cycle.
  assign full_set_s = pend_q  ? (2'b01 << pend_bank_q) : 2'b00;
  assign full_clr_s = rd_ok_s ? (2'b01 << rbank_q)     : 2'b00;

  assign in_ready    = in_ready_s;
  assign wen         = wen_q;
  assign wbank       = wbank_q;
  assign waddr       = waddr_q;
  assign wdata       = wdata_q;
  assign rbank       = rbank_q;
  assign rbank_valid = full_q[rbank_q];

  // Next-state logic for config, tile counters, ping-pong state and write port.
  always_comb begin
    ix0_d       = ix0_q;
    iy0_d       = iy0_q;
    ic1_d       = ic1_q;
    ix_d        = ix_q;
    iy_d        = iy_q;
    ic_d        = ic_q;
    lin_d       = lin_q;
    wptr_d      = wptr_q;
    rbank_d     = rbank_q;
    full_d      = full_q;
    pend_d      = 1'b0;
    pend_bank_d = pend_bank_q;
    wen_d       = 1'b0;
    wbank_d     = wbank_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    if (config_enable) begin
      ix0_d   = config_data[3*COUNTER_WIDTH-1 -: COUNTER_WIDTH];
      iy0_d   = config_data[2*COUNTER_WIDTH-1 -: COUNTER_WIDTH];
      ic1_d   = config_data[COUNTER_WIDTH-1:0];
      ix_d    = ZERO_C;
      iy_d    = ZERO_C;
      ic_d    = ZERO_C;
      lin_d   = ZERO_C;
      wptr_d  = 1'b0;
      rbank_d = 1'b0;
      full_d  = 2'b00;
    end else begin
      full_d  = (full_q | full_set_s) & ~full_clr_s;
      rbank_d = rd_ok_s ? ~rbank_q : rbank_q;
      if (accept_s) begin
        wen_d   = 1'b1;
        wbank_d = wptr_q;
        waddr_d = lin_q[BANK_ADDR_WIDTH-1:0];
        wdata_d = in_data;
        if (last_s) begin
          ix_d        = ZERO_C;
          iy_d        = ZERO_C;
          ic_d        = ZERO_C;
          lin_d       = ZERO_C;
          wptr_d      = ~wptr_q;
          pend_d      = 1'b1;
          pend_bank_d = wptr_q;
        end else begin
          lin_d = lin_q + ONE_C;
          ix_d  = ix_wrap_s ? ZERO_C : ix_q + ONE_C;
          if (ix_wrap_s) begin
            iy_d = iy_wrap_s ? ZERO_C : iy_q + ONE_C;
          end else begin
            iy_d = iy_q;
          end
          if (ix_wrap_s & iy_wrap_s) begin
            ic_d = ic_q + ONE_C;
          end else begin
            ic_d = ic_q;
          end
        end
      end else begin
        wen_d = 1'b0;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ix0_q       <= ZERO_C;
      iy0_q       <= ZERO_C;
      ic1_q       <= ZERO_C;
      ix_q        <= ZERO_C;
      iy_q        <= ZERO_C;
      ic_q        <= ZERO_C;
      lin_q       <= ZERO_C;
      wptr_q      <= 1'b0;
      rbank_q     <= 1'b0;
      full_q      <= 2'b00;
      pend_q      <= 1'b0;
      pend_bank_q <= 1'b0;
      wen_q       <= 1'b0;
      wbank_q     <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      ix0_q       <= ix0_d;
      iy0_q       <= iy0_d;
      ic1_q       <= ic1_d;
      ix_q        <= ix_d;
      iy_q        <= iy_d;
      ic_q        <= ic_d;
      lin_q       <= lin_d;
      wptr_q      <= wptr_d;
      rbank_q     <= rbank_d;
      full_q      <= full_d;
      pend_q      <= pend_d;
      pend_bank_q <= pend_bank_d;
      wen_q       <= wen_d;
      wbank_q     <= wbank_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
    end
  end

`ifdef INPUT_WRITE_ADDR_GEN_STATS_EN
  logic [COUNTER_WIDTH-1:0] stall_q, stall_d;

  // Saturating count of cycles a configured producer was held off.
  always_comb begin
    stall_d = stall_q;
    if (config_enable) begin
      stall_d = ZERO_C;
    end else if (in_valid & ~in_ready_s & cfg_ok_s & ~(&stall_q)) begin
      stall_d = stall_q + ONE_C;
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= ZERO_C;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule
